// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants and result type for the ripple-carry adder and its consumers.
package ripple_carry_adder_pkg;

  localparam int RCA_DEFAULT_WIDTH = 4;

  // {cout, sum} at the default width; benches pack reference sums into this.
  typedef struct packed {
    logic                         cout;
    logic [RCA_DEFAULT_WIDTH-1:0] sum;
  } rca_result_t;

endpackage

// File: rtl/rca_full_adder.sv
// Single-bit full-adder cell, the link of the ripple-carry chain.
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder with combinational sum and a one-cycle registered copy.
// Define RIPPLE_CARRY_ADDER_OVF_EN to add signed-overflow outputs ovf / ovf_q.
module ripple_carry_adder
  import ripple_carry_adder_pkg::*;
#(
  parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             out_valid
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  // carry[i] is the carry into cell i; carry[WIDTH] is the final carry-out.
  logic [WIDTH:0] carry;

  assign carry[0] = Cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    rca_full_adder u_fa (
      .a  (A[gi]),
      .b  (B[gi]),
      .ci (carry[gi]),
      .s  (S[gi]),
      .co (carry[gi+1])
    );
  end

  assign Cout = carry[WIDTH];

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             out_valid_d;
  logic             out_valid_q;

  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = S;
      cout_d      = Cout;
      out_valid_d = 1'b1;
    end
  end

  // Output register stage: reset wins over capture on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

`ifdef RIPPLE_CARRY_ADDER_OVF_EN
  logic ovf_d;

  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign ovf = carry[WIDTH-1] ^ carry[WIDTH];

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) ovf_d = ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder at the default width.
module tb_ripple_carry_adder;
  import ripple_carry_adder_pkg::*;

  localparam int W = RCA_DEFAULT_WIDTH;

  typedef struct packed {
    logic        ovf;
    rca_result_t res;
  } sb_entry_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic [W-1:0] S;
  logic         Cout;
  logic [W-1:0] sum_q;
  logic         cout_q;
  logic         out_valid;
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
  logic         ovf;
  logic         ovf_q;
`endif

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .S         (S),
    .Cout      (Cout),
    .sum_q     (sum_q),
    .cout_q    (cout_q),
    .out_valid (out_valid)
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    ,
    .ovf       (ovf),
    .ovf_q     (ovf_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  sb_entry_t sb_q[$];
  sb_entry_t reg_model;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic sb_entry_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic ci);
    sb_entry_t  e;
    logic [W:0] wide;
    int         sa, sb, ss;
    wide  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.res = wide;
    sa    = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb    = b[W-1] ? int'(b) - (1 << W) : int'(b);
    ss    = sa + sb + int'(ci);
    e.ovf = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
    return e;
  endfunction

  // Drive one cycle of stimulus, check the combinational outputs, then the registered ones.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic v, input logic r);
    sb_entry_t e;
    logic      exp_vld;
    A = a; B = b; Cin = ci; in_valid = v; rst = r;
    #1;
    e = ref_add(a, b, ci);
    check_eq("S", S, e.res.sum);
    check_eq("Cout", Cout, e.res.cout);
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    check_eq("ovf", ovf, e.ovf);
`endif
    exp_vld = v && !r;
    if (exp_vld) sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      sb_q.delete();
      reg_model = '0;
    end else if (exp_vld) begin
      if (sb_q.size() == 0) check_eq("sb_empty", 1, 0);
      else reg_model = sb_q.pop_front();
    end
    check_eq("out_valid", out_valid, exp_vld);
    check_eq("sum_q", sum_q, reg_model.res.sum);
    check_eq("cout_q", cout_q, reg_model.res.cout);
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    check_eq("ovf_q", ovf_q, reg_model.ovf);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reg_model = '0;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;

    step(4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(4'd3, 4'd4, 1'b0, 1'b1, 1'b1);

    step(4'd0, 4'd0, 1'b0, 1'b1, 1'b0);

    A = 4'd1; B = 4'd1; Cin = 1'b0; in_valid = 1'b0; rst = 1'b0;
    #1;
    check_eq("comb_1p1_S", S, 4'd2);
    check_eq("comb_1p1_Cout", Cout, 1'b0);

    step(4'd15, 4'd1, 1'b0, 1'b1, 1'b0);
    check_eq("wrap_sum_q", sum_q, 4'd0);
    check_eq("wrap_cout_q", cout_q, 1'b1);
    step(4'd15, 4'd15, 1'b1, 1'b1, 1'b0);
    check_eq("max_sum_q", sum_q, 4'd15);
    check_eq("max_cout_q", cout_q, 1'b1);

    step(4'd5, 4'd6, 1'b1, 1'b1, 1'b0);
    step(4'd3, 4'd6, 1'b1, 1'b0, 1'b0);
    check_eq("hold_sum_q", sum_q, 4'd12);
    check_eq("hold_S", S, 4'd10);
    step(4'd2, 4'd2, 1'b0, 1'b0, 1'b0);

    step(4'd9, 4'd9, 1'b0, 1'b1, 1'b1);
    check_eq("rst_sum_q", sum_q, 4'd0);
    step(4'd9, 4'd9, 1'b0, 1'b1, 1'b0);
    check_eq("resume_sum_q", sum_q, 4'd2);

`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    step(4'd7, 4'd1, 1'b0, 1'b1, 1'b0);
    check_eq("ovf_7p1", ovf_q, 1'b1);
    step(4'd8, 4'd8, 1'b0, 1'b1, 1'b0);
    check_eq("ovf_8p8", ovf_q, 1'b1);
    check_eq("cout_8p8", cout_q, 1'b1);
`endif

    for (int i = 0; i < 512; i++) begin
      logic [8:0] idx;
      idx = 9'(i);
      step(idx[3:0], idx[7:4], idx[8], (i % 7) != 3, (i % 61) == 60);
    end

    in_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
